mem_req_ctrl: RTL and testbench

- Request sequencer placed directly upstream of the single-port memory (memory_dut).
- Accepts read/write requests on a valid/ready interface and buffers them in a small FIFO.
- Issues each request to the memory as a one-cycle wren/rden strobe, waits for the memory's valid, then returns one response per request on a valid/ready response interface.
- A per-transaction timeout turns a missing memory valid into an error response, so the block never hangs.

---
 rtl/mem_req_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_mem_req_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: request sequencer in front of a single-port memory.
// Buffers read/write requests in a small FIFO, issues each one as a single-cycle
// wren/rden strobe, waits for the memory's valid (or a timeout) and returns one
// in-order response per request on a valid/ready interface.
module mem_req_ctrl #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4,   // power of two, >= 2
  parameter int unsigned TIMEOUT    = 16   // WAIT cycles before an error response, >= 1
) (
  input  logic                        clk,
  input  logic                        reset,      // asynchronous, active low
  // request interface
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [ADDR_WIDTH-1:0]       req_addr,
  input  logic [DATA_WIDTH-1:0]       req_wdata,
  // response interface
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic                        rsp_write,
  output logic                        rsp_err,
  output logic [DATA_WIDTH-1:0]       rsp_data,
  // memory interface
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic [DATA_WIDTH-1:0]       mem_wdata,
  output logic                        mem_wren,
  output logic                        mem_rden,
  input  logic [DATA_WIDTH-1:0]       mem_rdata,
  input  logic                        mem_valid,
  // status
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  localparam logic [CntW-1:0] FullCount = CntW'(FIFO_DEPTH);
  localparam logic [TmoW-1:0] TmoLast   = TmoW'(TIMEOUT);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  // ---------------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------------
  logic                  fifo_write_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr_q  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_wdata_q [FIFO_DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic   push, pop;
  state_e state_q, state_d;

  // Ready comes from the registered count only, so a full FIFO refuses a push
  // even when the FSM pops in the same cycle. Held low while reset is asserted.
  assign req_ready  = reset && (count_q != FullCount);
  assign push       = req_valid && req_ready;
  assign pop        = (state_q == StIdle) && (count_q != '0);
  assign fifo_count = count_q;

  // FIFO pointer and occupancy next-state; pointers wrap naturally (power-of-two depth)
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents need no reset since the count qualifies them
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_write_q[wr_ptr_q] <= req_write;
      fifo_addr_q[wr_ptr_q]  <= req_addr;
      fifo_wdata_q[wr_ptr_q] <= req_wdata;
    end
  end

  // FIFO pointer and count registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencing FSM with registered outputs
  // ---------------------------------------------------------------------------
  logic                  cur_write_q, cur_write_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  mem_wren_q,  mem_wren_d;
  logic                  mem_rden_q,  mem_rden_d;
  logic [TmoW-1:0]       tmo_cnt_q,   tmo_cnt_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic                  rsp_err_q,   rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_data_q,  rsp_data_d;

  // FSM next-state: strobes are computed a cycle early so they are high only in ISSUE
  always_comb begin
    state_d     = state_q;
    cur_write_d = cur_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wren_d  = 1'b0;
    mem_rden_d  = 1'b0;
    tmo_cnt_d   = tmo_cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;

    unique case (state_q)
      StIdle: begin
        if (pop) begin
          cur_write_d = fifo_write_q[rd_ptr_q];
          mem_addr_d  = fifo_addr_q[rd_ptr_q];
          mem_wdata_d = fifo_wdata_q[rd_ptr_q];
          mem_wren_d  = fifo_write_q[rd_ptr_q];
          mem_rden_d  = !fifo_write_q[rd_ptr_q];
          state_d     = StIssue;
        end
      end
      StIssue: begin
        // mem_valid is deliberately not looked at here
        tmo_cnt_d = '0;
        state_d   = StWait;
      end
      StWait: begin
        if (mem_valid) begin
          // A valid on the final timeout cycle still counts as success
          rsp_valid_d = 1'b1;
          rsp_write_d = cur_write_q;
          rsp_err_d   = 1'b0;
          rsp_data_d  = cur_write_q ? '0 : mem_rdata;
          state_d     = StResp;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
          if (tmo_cnt_d == TmoLast) begin
            rsp_valid_d = 1'b1;
            rsp_write_d = cur_write_q;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
            state_d     = StResp;
          end
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cur_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wren_q  <= 1'b0;
      mem_rden_q  <= 1'b0;
      tmo_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_write_q <= cur_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wren_q  <= mem_wren_d;
      mem_rden_q  <= mem_rden_d;
      tmo_cnt_q   <= tmo_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wren  = mem_wren_q;
  assign mem_rden  = mem_rden_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl: directed plus randomized scoreboard bench for mem_req_ctrl.
// A memory model with per-request response delay (0 = never answers) stands in
// for the memory; expected responses are computed at request acceptance.
module tb_mem_req_ctrl;

  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int DEP = 4;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_write;
  logic          rsp_err;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wren;
  logic          mem_rden;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_valid = 1'b0;
  logic [2:0]    fifo_count;

  always #5 clk = ~clk;

  mem_req_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEP),
    .TIMEOUT   (TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_write (rsp_write),
    .rsp_err   (rsp_err),
    .rsp_data  (rsp_data),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wren  (mem_wren),
    .mem_rden  (mem_rden),
    .mem_rdata (mem_rdata),
    .mem_valid (mem_valid),
    .fifo_count(fifo_count)
  );

  typedef struct packed {
    logic          wr;
    logic          err;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  int            dly_q[$];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] mem_arr [256];

  int n_vec  = 0;
  int n_miss = 0;
  int rden_cycles = 0;
  int rsp_count = 0;

  logic rand_mode = 1'b0;
  logic rand_rdy  = 1'b1;
  logic rdy_dir   = 1'b1;
  assign rsp_ready = rand_mode ? rand_rdy : rdy_dir;

  function automatic void check(input string name, input logic [DW-1:0] act,
                                input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = '0;
      mem_arr[i] = '0;
    end
  end

  // Random response backpressure, changed just after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1 rand_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  // Memory model: answers a strobe after the delay queued with that request
  initial begin
    int            cd;
    int            d;
    logic [DW-1:0] rd;
    logic [DW-1:0] pend;
    cd   = 0;
    pend = '0;
    forever begin
      @(posedge clk);
      mem_valid <= 1'b0;
      if (!reset) begin
        cd = 0;
      end else if (mem_wren || mem_rden) begin
        if (dly_q.size() == 0) begin
          check("strobe_without_request", 1, 0);
          d = 1;
        end else begin
          d = dly_q.pop_front();
        end
        rd = mem_wren ? DW'($urandom) | 1 : mem_arr[mem_addr];
        if (mem_wren) mem_arr[mem_addr] = mem_wdata;
        if (d == 1) begin
          mem_valid <= 1'b1;
          mem_rdata <= rd;
          cd = 0;
        end else begin
          cd   = (d == 0) ? 0 : d - 1;
          pend = rd;
        end
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          mem_valid <= 1'b1;
          mem_rdata <= pend;
        end
      end
    end
  end

  // Monitor: scoreboard pops on handshake, checks hold stability and strobes
  initial begin
    logic          hold, pstrobe;
    logic [DW-1:0] h_data;
    logic          h_err, h_wr;
    exp_t          e;
    hold = 1'b0;
    pstrobe = 1'b0;
    h_data = '0;
    h_err = 1'b0;
    h_wr = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        hold = 1'b0;
        pstrobe = 1'b0;
      end else begin
        if (mem_rden) rden_cycles++;
        if (mem_wren && mem_rden) check("strobe_both", 1, 0);
        if (pstrobe && (mem_wren || mem_rden)) check("strobe_two_cycles", 1, 0);
        pstrobe = mem_wren || mem_rden;
        if (hold) begin
          check("hold_valid", rsp_valid, 1);
          check("hold_data", rsp_data, h_data);
          check("hold_err", rsp_err, h_err);
          check("hold_write", rsp_write, h_wr);
        end
        if (rsp_valid && rsp_ready) begin
          rsp_count++;
          hold = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected_rsp", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("rsp_write", rsp_write, e.wr);
            check("rsp_err", rsp_err, e.err);
            check("rsp_data", rsp_data, e.data);
          end
        end else if (rsp_valid) begin
          hold   = 1'b1;
          h_data = rsp_data;
          h_err  = rsp_err;
          h_wr   = rsp_write;
        end else begin
          hold = 1'b0;
        end
      end
    end
  end

  // Present one request, wait (bounded) for acceptance, record its expected response
  task automatic send(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                      input int dly);
    exp_t e;
    int   guard;
    logic acc;
    guard = 0;
    acc = 1'b0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = data;
    while (!acc && guard < 300) begin
      @(negedge clk);
      if (req_ready) begin
        acc    = 1'b1;
        e.wr   = wr;
        e.err  = (dly == 0);
        e.data = '0;
        if (wr) ref_mem[addr] = data;
        else if (dly != 0) e.data = ref_mem[addr];
        exp_q.push_back(e);
        dly_q.push_back(dly);
      end
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) check("req_accept_timeout", 0, 1);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < budget) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Cycles from the acceptance edge until rsp_valid is seen
  task automatic latency(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int snap;
    int r, dly;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_mem_wren", mem_wren, 0);
    check("rst_mem_rden", mem_rden, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_rsp_data", rsp_data, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rel_req_ready", req_ready, 1);

    // Single write then read with latency and single rden strobe
    send(1'b1, 8'h10, 32'hDEADBEEF, 1);
    wait_idle(100);
    snap = rden_cycles;
    send(1'b0, 8'h10, '0, 1);
    latency(lat);
    check("read_latency", lat, 3);
    check("read_data_direct", rsp_data, 32'hDEADBEEF);
    wait_idle(100);
    check("rden_cycles", rden_cycles - snap, 1);

    // FIFO fill under backpressure
    rdy_dir = 1'b0;
    for (int i = 1; i <= 5; i++) send(1'b1, AW'(i), DW'(i * 32'h11), 1);
    check("fill_count", fifo_count, 4);
    check("fill_ready", req_ready, 0);
    rdy_dir = 1'b1;
    for (int i = 1; i <= 5; i++) send(1'b0, AW'(i), '0, $urandom_range(1, 3));
    wait_idle(300);

    // Response backpressure with a request queued behind it
    rdy_dir = 1'b0;
    send(1'b0, 8'h03, '0, 2);
    send(1'b1, 8'h40, 32'h1234, 1);
    latency(lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid", rsp_valid, 1);
      check("bp_data", rsp_data, 32'h33);
      check("bp_no_strobe", mem_wren | mem_rden, 0);
    end
    rdy_dir = 1'b1;
    @(posedge clk);
    #1;
    check("bp_released", rsp_valid, 0);
    check("bp_idle_no_strobe", mem_wren | mem_rden, 0);
    @(posedge clk);
    #1;
    check("bp_next_issue", mem_wren, 1);
    wait_idle(100);

    // Timeout on a read, next queued request still completes
    send(1'b0, 8'h20, '0, 0);
    send(1'b1, 8'h21, 32'hA5A5A5A5, 1);
    latency(lat);
    check("tmo_latency", lat, TMO + 1);
    check("tmo_err", rsp_err, 1);
    check("tmo_data", rsp_data, 0);
    wait_idle(100);
    send(1'b0, 8'h21, '0, 1);
    wait_idle(100);

    // mem_valid on the last WAIT cycle wins over the timeout
    send(1'b0, 8'h10, '0, TMO);
    latency(lat);
    check("race_latency", lat, TMO + 2);
    check("race_err", rsp_err, 0);
    check("race_data", rsp_data, 32'hDEADBEEF);
    wait_idle(100);

    // Reset in WAIT with two requests queued
    send(1'b0, 8'h10, '0, 0);
    send(1'b0, 8'h01, '0, 1);
    send(1'b0, 8'h02, '0, 1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_strobe", mem_wren | mem_rden, 0);
    check("mid_rst_mem_addr", mem_addr, 0);
    check("mid_rst_rsp_err", rsp_err, 0);
    exp_q.delete();
    dly_q.delete();
    snap = rsp_count;
    @(negedge clk);
    reset = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("no_rsp_after_rst", rsp_count - snap, 0);
    send(1'b0, 8'h05, '0, 1);
    wait_idle(100);
    check("post_rst_rsp", rsp_count - snap, 1);

    // Randomized traffic with random backpressure
    rand_mode = 1'b1;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) dly = 0;
      else if (r == 1) dly = TMO;
      else dly = $urandom_range(1, 4);
      send(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom), dly);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rand_mode = 1'b0;
    wait_idle(20000);
    check("final_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
